craft_round_controller: RTL and testbench

- Sequencing FSM for the nibble-serial CRAFT datapath: one 4-bit cell per clock, 16 cells per round, NUM_ROUNDS rounds.
- Drives the mix-columns cell controls (CM0/CM1), the key-register round index and key-half select (r, CK0), and load/unload strobes.
- Exposes a start/ready/done handshake to the encryption wrapper.
- Contains no datapath state of its own.

---
 rtl/craft_round_controller.sv | 167 ++++++++++++++++
 tb/tb_craft_round_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/craft_round_controller.sv
// Sequencing FSM for the nibble-serial CRAFT datapath: one 4-bit cell per clock,
// 16 cells per round. Every output is a flop computed from the next-state values.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start, ready=1
//   S_LOAD   | shifting in 16 plaintext nibbles
//   S_ROUND  | processing 16 cells per round, NUM_ROUNDS rounds
//   S_UNLOAD | shifting out 16 ciphertext nibbles, done on the last one
module craft_round_controller #(
    parameter int NUM_ROUNDS = 32,
    parameter int NIBBLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       ready,
    output logic       busy,
    output logic       load_en,
    output logic       round_en,
    output logic       out_valid,
    output logic       done,
    output logic [3:0] nib_idx,
    output logic [7:0] round,
    output logic       cm0,
    output logic       cm1,
    output logic       ck0,
    output logic       last_round
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROUND  = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);
    localparam logic [7:0] LAST_RND = 8'(NUM_ROUNDS - 1);

    state_t     state_q, state_d;
    logic [3:0] nib_q, nib_d;
    logic [7:0] round_q, round_d;

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic load_en_q, load_en_d;
    logic round_en_q, round_en_d;
    logic out_valid_q, out_valid_d;
    logic done_q, done_d;
    logic cm0_q, cm0_d;
    logic cm1_q, cm1_d;
    logic ck0_q, ck0_d;
    logic last_round_q, last_round_d;

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        round_d = round_q;

        // A stall leaves every _d equal to its _q, so outputs (including done) hold.
        if (!stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        nib_d   = 4'd0;
                        round_d = 8'd0;
                    end
                end
                S_LOAD: begin
                    if (nib_q == LAST_NIB) begin
                        state_d = S_ROUND;
                        nib_d   = 4'd0;
                    end else begin
                        nib_d = nib_q + 4'd1;
                    end
                end
                S_ROUND: begin
                    if (nib_q == LAST_NIB) begin
                        nib_d = 4'd0;
                        if (round_q == LAST_RND) begin
                            state_d = S_UNLOAD;
                        end else begin
                            round_d = round_q + 8'd1;
                        end
                    end else begin
                        nib_d = nib_q + 4'd1;
                    end
                end
                S_UNLOAD: begin
                    if (nib_q == LAST_NIB) begin
                        state_d = S_IDLE;
                        nib_d   = 4'd0;
                        round_d = 8'd0;
                    end else begin
                        nib_d = nib_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    nib_d   = 4'd0;
                    round_d = 8'd0;
                end
            endcase
        end

        ready_d      = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        load_en_d    = (state_d == S_LOAD);
        round_en_d   = (state_d == S_ROUND);
        out_valid_d  = (state_d == S_UNLOAD);
        done_d       = (state_d == S_UNLOAD) && (nib_d == LAST_NIB);
        // Rows 0-1 (cells 0..7) get the first column add, row 0 (cells 0..3) the second.
        cm0_d        = round_en_d && (nib_d < 4'd8);
        cm1_d        = round_en_d && (nib_d < 4'd4);
        ck0_d        = ~round_d[0];
        last_round_d = busy_d && round_en_d && (round_d == LAST_RND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nib_q        <= 4'd0;
            round_q      <= 8'd0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            load_en_q    <= 1'b0;
            round_en_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            cm0_q        <= 1'b0;
            cm1_q        <= 1'b0;
            ck0_q        <= 1'b1;
            last_round_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_q        <= nib_d;
            round_q      <= round_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            load_en_q    <= load_en_d;
            round_en_q   <= round_en_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            cm0_q        <= cm0_d;
            cm1_q        <= cm1_d;
            ck0_q        <= ck0_d;
            last_round_q <= last_round_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign load_en    = load_en_q;
    assign round_en   = round_en_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign nib_idx    = nib_q;
    assign round      = round_q;
    assign cm0        = cm0_q;
    assign cm1        = cm1_q;
    assign ck0        = ck0_q;
    assign last_round = last_round_q;

endmodule

// File: tb/tb_craft_round_controller.sv
// Bench for craft_round_controller: a closed-form timeline model predicts every output
// per cycle; done latencies go through a scoreboard queue.
module tb_craft_round_controller;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stall;

    logic       a_ready, a_busy, a_load_en, a_round_en, a_out_valid, a_done;
    logic [3:0] a_nib;
    logic [7:0] a_round;
    logic       a_cm0, a_cm1, a_ck0, a_last;

    logic       b_ready, b_busy, b_load_en, b_round_en, b_out_valid, b_done;
    logic [3:0] b_nib;
    logic [7:0] b_round;
    logic       b_cm0, b_cm1, b_ck0, b_last;

    craft_round_controller #(.NUM_ROUNDS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .ready(a_ready), .busy(a_busy), .load_en(a_load_en), .round_en(a_round_en),
        .out_valid(a_out_valid), .done(a_done), .nib_idx(a_nib), .round(a_round),
        .cm0(a_cm0), .cm1(a_cm1), .ck0(a_ck0), .last_round(a_last)
    );

    craft_round_controller #(.NUM_ROUNDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .ready(b_ready), .busy(b_busy), .load_en(b_load_en), .round_en(b_round_en),
        .out_valid(b_out_valid), .done(b_done), .nib_idx(b_nib), .round(b_round),
        .cm0(b_cm0), .cm1(b_cm1), .ck0(b_ck0), .last_round(b_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int last_done_abs = -1;
    bit sel = 1'b0;

    // {ready,busy,load_en,round_en,out_valid,done,nib[3:0],round[7:0],cm0,cm1,ck0,last}
    logic [21:0] obs_a, obs_b, obs;
    assign obs_a = {a_ready, a_busy, a_load_en, a_round_en, a_out_valid, a_done,
                    a_nib, a_round, a_cm0, a_cm1, a_ck0, a_last};
    assign obs_b = {b_ready, b_busy, b_load_en, b_round_en, b_out_valid, b_done,
                    b_nib, b_round, b_cm0, b_cm1, b_ck0, b_last};
    assign obs   = sel ? obs_b : obs_a;

    // t counts unstalled edges since start was taken; t=1 is the first LOAD cycle.
    function automatic logic [21:0] exp_vec(input int t, input int nr);
        logic rdy, bsy, ld, rn, ov, dn, c0, c1, k0, lr;
        logic [3:0] nb;
        logic [7:0] rd;
        int u;
        rdy = 1'b1; bsy = 1'b0; ld = 1'b0; rn = 1'b0; ov = 1'b0; dn = 1'b0;
        c0 = 1'b0; c1 = 1'b0; k0 = 1'b1; lr = 1'b0; nb = 4'd0; rd = 8'd0;
        if (t >= 1 && t <= 16) begin
            rdy = 1'b0; bsy = 1'b1; ld = 1'b1; nb = 4'(t - 1);
        end else if (t >= 17 && t < 17 + 16 * nr) begin
            u = t - 17;
            rdy = 1'b0; bsy = 1'b1; rn = 1'b1;
            nb = 4'(u % 16); rd = 8'(u / 16);
            c0 = (u % 16) < 8; c1 = (u % 16) < 4;
            k0 = ~rd[0]; lr = ((u / 16) == nr - 1);
        end else if (t >= 17 + 16 * nr && t <= 32 + 16 * nr) begin
            u = t - 17 - 16 * nr;
            rdy = 1'b0; bsy = 1'b1; ov = 1'b1;
            nb = 4'(u); rd = 8'(nr - 1); k0 = ~rd[0]; dn = (u == 15);
        end
        return {rdy, bsy, ld, rn, ov, dn, nb, rd, c0, c1, k0, lr};
    endfunction

    task automatic run_enc(input bit use2, input int nr,
                           input int s1_at, input int s1_len,
                           input int s2_at, input int s2_len,
                           input int glitch_at, input bit hold, input int abort_at,
                           output int e0);
        int teff, end_t, s1c, s2c, done_first, done_last, done_cnt;
        int load_cnt, rnd_cnt, ov_cnt, last_cnt, exp_lat;
        bit stl, fin, aborted;
        logic [21:0] ev;
        sel = use2;
        end_t = 33 + 16 * nr;
        s1c = 0; s2c = 0; done_first = -1; done_last = -1; done_cnt = 0;
        load_cnt = 0; rnd_cnt = 0; ov_cnt = 0; last_cnt = 0;
        fin = 1'b0; aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        if (!hold) start = 1'b0;
        if (abort_at < 0) exp_q.push_back(32 + 16 * nr + s1_len + s2_len);
        teff = 1;
        while (!fin) begin
            ev = exp_vec(teff, nr);
            checks++;
            if (obs !== ev) begin
                failures++;
                $display("FAIL timeline t=%0d cyc=%0d got=%h expected=%h", teff, cyc, obs, ev);
            end
            if (obs[19]) load_cnt++;
            if (obs[18]) rnd_cnt++;
            if (obs[17]) ov_cnt++;
            if (obs[0])  last_cnt++;
            if (obs[16]) begin
                if (done_first < 0) begin
                    done_first = cyc - e0 + 1;
                    last_done_abs = cyc;
                end
                done_last = cyc - e0 + 1;
                done_cnt++;
            end
            if (teff == end_t) begin
                fin = 1'b1;
            end else if (teff == abort_at) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (obs !== exp_vec(0, nr)) begin
                        failures++;
                        $display("FAIL abort_idle k=%0d got=%h expected=%h", k, obs, exp_vec(0, nr));
                    end
                    if (obs[16]) done_cnt++;
                    @(negedge clk);
                end
                checks++;
                if (done_cnt !== 0) begin
                    failures++;
                    $display("FAIL abort_no_done got=%0d expected=0", done_cnt);
                end
                fin = 1'b1;
                aborted = 1'b1;
            end else begin
                stl = 1'b0;
                if (teff == s1_at && s1c < s1_len) begin
                    stl = 1'b1; s1c++;
                end else if (teff == s2_at && s2c < s2_len) begin
                    stl = 1'b1; s2c++;
                end
                stall = stl;
                if (teff == glitch_at) start = 1'b1;
                else if (!hold) start = 1'b0;
                @(negedge clk);
                if (!stl) teff++;
            end
        end
        stall = 1'b0;
        if (!aborted) begin
            exp_lat = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (done_last !== exp_lat) begin
                failures++;
                $display("FAIL done_latency got=%0d expected=%0d", done_last, exp_lat);
            end
            checks++;
            if (done_cnt !== 1 + s2_len) begin
                failures++;
                $display("FAIL done_width got=%0d expected=%0d", done_cnt, 1 + s2_len);
            end
            if (s1_len == 0 && s2_len == 0) begin
                checks++;
                if (load_cnt !== 16 || rnd_cnt !== 16 * nr || ov_cnt !== 16 || last_cnt !== 16) begin
                    failures++;
                    $display("FAIL phase_counts got=%0d/%0d/%0d/%0d expected=16/%0d/16/16",
                             load_cnt, rnd_cnt, ov_cnt, last_cnt, 16 * nr);
                end
                checks++;
                if (done_first !== 32 + 16 * nr) begin
                    failures++;
                    $display("FAIL done_first got=%0d expected=%0d", done_first, 32 + 16 * nr);
                end
            end
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs !== exp_vec(0, 32)) begin
                failures++;
                $display("FAIL %s k=%0d got=%h expected=%h", tag, k, obs, exp_vec(0, 32));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_idle", 10);
    endtask

    task automatic test_single;
        int e0;
        run_enc(1'b0, 32, -1, 0, -1, 0, -1, 1'b0, -1, e0);
    endtask

    task automatic test_stall;
        int e0;
        run_enc(1'b0, 32, 72, 5, 544, 3, -1, 1'b0, -1, e0);
    endtask

    task automatic test_abort;
        int e0;
        run_enc(1'b0, 32, -1, 0, -1, 0, -1, 1'b0, 181, e0);
        run_enc(1'b0, 32, -1, 0, -1, 0, -1, 1'b0, -1, e0);
    endtask

    task automatic test_handshake;
        int e0;
        sel = 1'b0;
        stall = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0; start = 1'b0;
        check_idle("start_under_stall", 2);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle("rst_beats_start", 2);
        run_enc(1'b0, 32, -1, 0, -1, 0, 100, 1'b0, -1, e0);
    endtask

    task automatic test_back_to_back;
        int e0, d1;
        run_enc(1'b0, 32, -1, 0, -1, 0, -1, 1'b1, -1, e0);
        d1 = last_done_abs;
        run_enc(1'b0, 32, -1, 0, -1, 0, -1, 1'b1, -1, e0);
        start = 1'b0;
        checks++;
        if (last_done_abs - d1 !== 545) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d expected=545", last_done_abs - d1);
        end
        check_idle("after_b2b", 2);
    endtask

    task automatic test_two_rounds;
        int e0;
        start = 1'b0;
        repeat (80) @(negedge clk);
        run_enc(1'b1, 2, -1, 0, -1, 0, -1, 1'b0, -1, e0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_stall;
        test_abort;
        test_handshake;
        test_back_to_back;
        test_two_rounds;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
